// File: rtl/stall_flush_controller.sv
// -----------------------------------------------------------------------------
// stall_flush_controller
//   Hazard controller for a 5-stage in-order pipeline.  Decides, every cycle,
//   which pipeline registers hold (stall) and which receive a bubble (flush),
//   covering memory-stage waits, multi-cycle mul/div in Execute, taken
//   redirects and load-use hazards (priority in that order).
//
//   Stall/flush outputs are combinational from the FSM state and the
//   current inputs; only the FSM state, the mul/div counter and the
//   resume flag are registered.
//
// Parameters
//   MULDIV_LATENCY  cycles a mul/div occupies Execute (1..16)
//
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   D_rs1, D_rs2, D_opcode      Decode source registers and opcode
//   E_rd, E_opcode              Execute destination register and opcode
//   E_reg_write_enable          Execute instruction writes rd
//   E_is_muldiv                 Execute holds an M-extension instruction
//   E_branch_taken              Execute redirects the PC
//   M_mem_req, M_mem_ready      Memory-stage request / completion
//   F/D/E/M_stall               hold the named stage's register
//   D/E/M/W_flush               load a bubble into the named stage's register
//   stall_cycles, flush_events  performance counters (HAZARD_PERF_CNT_EN only)
//
// Build option
//   HAZARD_PERF_CNT_EN  adds the two 32-bit performance counters.
// -----------------------------------------------------------------------------
module stall_flush_controller #(
  parameter int unsigned MULDIV_LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  D_rs1,
  input  logic [4:0]  D_rs2,
  input  logic [6:0]  D_opcode,
  input  logic [4:0]  E_rd,
  input  logic [6:0]  E_opcode,
  input  logic        E_reg_write_enable,
  input  logic        E_is_muldiv,
  input  logic        E_branch_taken,
  input  logic        M_mem_req,
  input  logic        M_mem_ready,
  output logic        F_stall,
  output logic        D_stall,
  output logic        E_stall,
  output logic        M_stall,
  output logic        D_flush,
  output logic        E_flush,
  output logic        M_flush,
  output logic        W_flush
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_events
`endif
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned CTR_W = 32;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MD_WAIT  = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   md_cnt, md_cnt_nxt;
  logic               ret_md, ret_md_nxt;
  logic               redirect;

  logic               mem_wait;
  logic               rs1_read;
  logic               rs2_read;
  logic               load_use;

  // Hazard detection terms
  always_comb begin
    mem_wait = M_mem_req && !M_mem_ready;
    rs1_read = !((D_opcode == OP_LUI) || (D_opcode == OP_AUIPC) || (D_opcode == OP_JAL));
    rs2_read = (D_opcode == OP_REG) || (D_opcode == OP_STORE) || (D_opcode == OP_BRANCH);
    // x0 never hazards: E_rd != 0 implies any matching source is non-zero too
    load_use = (E_opcode == OP_LOAD) && E_reg_write_enable && (E_rd != 5'd0) &&
               ((rs1_read && (D_rs1 == E_rd)) || (rs2_read && (D_rs2 == E_rd)));
  end

  // Next-state and stall/flush decode
  always_comb begin
    state_nxt  = state;
    md_cnt_nxt = md_cnt;
    ret_md_nxt = ret_md;
    redirect   = 1'b0;
    F_stall    = 1'b0;
    D_stall    = 1'b0;
    E_stall    = 1'b0;
    M_stall    = 1'b0;
    D_flush    = 1'b0;
    E_flush    = 1'b0;
    M_flush    = 1'b0;
    W_flush    = 1'b0;

    unique case (state)
      RUN: begin
        if (mem_wait) begin
          {F_stall, D_stall, E_stall, M_stall} = 4'b1111;
          W_flush    = 1'b1;
          ret_md_nxt = 1'b0;
          state_nxt  = MEM_WAIT;
        end else if (E_is_muldiv && (MULDIV_LATENCY > 1)) begin
          // This cycle is the first of MULDIV_LATENCY-1 stall cycles
          {F_stall, D_stall, E_stall} = 3'b111;
          M_flush    = 1'b1;
          md_cnt_nxt = CNT_W'(MULDIV_LATENCY - 2);
          state_nxt  = MD_WAIT;
        end else if (E_branch_taken) begin
          D_flush  = 1'b1;
          E_flush  = 1'b1;
          redirect = 1'b1;
        end else if (load_use) begin
          F_stall = 1'b1;
          D_stall = 1'b1;
          E_flush = 1'b1;
        end
      end

      MD_WAIT: begin
        if (mem_wait) begin
          // md_cnt is held until the memory wait resolves
          {F_stall, D_stall, E_stall, M_stall} = 4'b1111;
          W_flush    = 1'b1;
          ret_md_nxt = 1'b1;
          state_nxt  = MEM_WAIT;
        end else if (md_cnt != '0) begin
          {F_stall, D_stall, E_stall} = 3'b111;
          M_flush    = 1'b1;
          md_cnt_nxt = md_cnt - CNT_W'(1);
        end else begin
          state_nxt = RUN;
        end
      end

      MEM_WAIT: begin
        if (!M_mem_ready) begin
          {F_stall, D_stall, E_stall, M_stall} = 4'b1111;
          W_flush = 1'b1;
        end else begin
          state_nxt  = ret_md ? MD_WAIT : RUN;
          ret_md_nxt = 1'b0;
        end
      end

      default: begin
        state_nxt = RUN;
      end
    endcase

    // Reset drains the pipeline: bubbles everywhere, nothing held
    if (rst) begin
      {F_stall, D_stall, E_stall, M_stall} = 4'b0000;
      {D_flush, E_flush, M_flush, W_flush} = 4'b1111;
      redirect = 1'b0;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= RUN;
      md_cnt <= '0;
      ret_md <= 1'b0;
    end else begin
      state  <= state_nxt;
      md_cnt <= md_cnt_nxt;
      ret_md <= ret_md_nxt;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  // Performance counters, wrapping at 2^32
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (F_stall) begin
        stall_cycles <= stall_cycles + CTR_W'(1);
      end
      if (redirect) begin
        flush_events <= flush_events + CTR_W'(1);
      end
    end
  end
`else
  // No counters in this build; the redirect strobe only feeds them
  logic unused_redirect;
  always_comb unused_redirect = redirect;
`endif

endmodule

// File: tb/tb_stall_flush_controller.sv
// -----------------------------------------------------------------------------
// tb_stall_flush_controller
//   Self-checking bench: directed hazard scenarios followed by randomized
//   traffic, compared each cycle against a behavioural pipeline-hazard model.
//   Define HAZARD_PERF_CNT_EN to also check the performance counters.
// -----------------------------------------------------------------------------
module tb_stall_flush_controller;

  localparam int unsigned LAT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  D_rs1, D_rs2, E_rd;
  logic [6:0]  D_opcode, E_opcode;
  logic        E_reg_write_enable, E_is_muldiv, E_branch_taken;
  logic        M_mem_req, M_mem_ready;
  logic        F_stall, D_stall, E_stall, M_stall;
  logic        D_flush, E_flush, M_flush, W_flush;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles, flush_events;
`endif

  always #5 clk = ~clk;

  stall_flush_controller #(.MULDIV_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .D_rs1(D_rs1), .D_rs2(D_rs2), .D_opcode(D_opcode),
    .E_rd(E_rd), .E_opcode(E_opcode),
    .E_reg_write_enable(E_reg_write_enable),
    .E_is_muldiv(E_is_muldiv), .E_branch_taken(E_branch_taken),
    .M_mem_req(M_mem_req), .M_mem_ready(M_mem_ready),
    .F_stall(F_stall), .D_stall(D_stall), .E_stall(E_stall), .M_stall(M_stall),
    .D_flush(D_flush), .E_flush(E_flush), .M_flush(M_flush), .W_flush(W_flush)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cycles(stall_cycles), .flush_events(flush_events)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Behavioural model: pending memory wait, remaining mul/div stall cycles
  bit          m_mem_pend;
  bit          m_md_busy;
  int          m_md_left;
  logic [31:0] m_stall_cnt;
  logic [31:0] m_flush_cnt;

  function automatic bit reads_rs1(input logic [6:0] op);
    return !(op == 7'b0110111 || op == 7'b0010111 || op == 7'b1101111);
  endfunction

  function automatic bit reads_rs2(input logic [6:0] op);
    return (op == 7'b0110011 || op == 7'b0100011 || op == 7'b1100011);
  endfunction

  function automatic bit load_hazard();
    if (E_opcode != 7'b0000011 || !E_reg_write_enable || E_rd == 5'd0) return 1'b0;
    return (reads_rs1(D_opcode) && D_rs1 == E_rd) || (reads_rs2(D_opcode) && D_rs2 == E_rd);
  endfunction

  // One clock cycle with the inputs currently applied.
  // Expected vector: {F,D,E,M stall, D,E,M,W flush}
  task automatic cycle(input string tag);
    logic [7:0] exp;
    bit         n_pend, n_busy, redirect;
    int         n_left;
    exp = 8'b0; redirect = 1'b0;
    n_pend = m_mem_pend; n_busy = m_md_busy; n_left = m_md_left;
    if (rst) begin
      exp = 8'b0000_1111;
      n_pend = 1'b0; n_busy = 1'b0; n_left = 0;
    end else if (m_mem_pend) begin
      if (!M_mem_ready) exp = 8'b1111_0001;
      else n_pend = 1'b0;
    end else if (M_mem_req && !M_mem_ready) begin
      exp = 8'b1111_0001;
      n_pend = 1'b1;
    end else if (m_md_busy) begin
      if (m_md_left > 0) begin
        exp = 8'b1110_0010;
        n_left = m_md_left - 1;
      end else begin
        n_busy = 1'b0;
      end
    end else if (E_is_muldiv && LAT > 1) begin
      // LAT-1 stall cycles in total, this being the first
      exp = 8'b1110_0010;
      n_busy = 1'b1;
      n_left = int'(LAT) - 1 - 1;
    end else if (E_branch_taken) begin
      exp = 8'b0000_1100;
      redirect = 1'b1;
    end else if (load_hazard()) begin
      exp = 8'b1100_0100;
    end

    @(negedge clk);
    check(tag, 32'({F_stall, D_stall, E_stall, M_stall, D_flush, E_flush, M_flush, W_flush}),
          32'(exp));
`ifdef HAZARD_PERF_CNT_EN
    check({tag, "_stall_cnt"}, stall_cycles, m_stall_cnt);
    check({tag, "_flush_cnt"}, flush_events, m_flush_cnt);
`endif
    @(posedge clk);
    #1;
    m_mem_pend = n_pend; m_md_busy = n_busy; m_md_left = n_left;
    if (rst) begin
      m_stall_cnt = '0;
      m_flush_cnt = '0;
    end else begin
      m_stall_cnt = m_stall_cnt + 32'(exp[7]);
      m_flush_cnt = m_flush_cnt + 32'(redirect);
    end
  endtask

  task automatic idle();
    rst = 1'b0;
    D_rs1 = 5'd0; D_rs2 = 5'd0; D_opcode = 7'b0010011;
    E_rd = 5'd0; E_opcode = 7'b0010011; E_reg_write_enable = 1'b0;
    E_is_muldiv = 1'b0; E_branch_taken = 1'b0;
    M_mem_req = 1'b0; M_mem_ready = 1'b0;
  endtask

  logic [6:0] op_tab [8];

  initial begin
    op_tab[0] = 7'b0000011; op_tab[1] = 7'b0110011; op_tab[2] = 7'b0100011;
    op_tab[3] = 7'b1100011; op_tab[4] = 7'b0110111; op_tab[5] = 7'b0010111;
    op_tab[6] = 7'b1101111; op_tab[7] = 7'b0010011;

    idle();
    rst = 1'b1;
    @(posedge clk);
    #1;
    m_mem_pend = 1'b0; m_md_busy = 1'b0; m_md_left = 0;
    m_stall_cnt = '0; m_flush_cnt = '0;

    cycle("reset");
    idle();
    cycle("idle");

    // lw x5 ; add x6,x5,x1 -> one-cycle load-use stall
    E_opcode = 7'b0000011; E_rd = 5'd5; E_reg_write_enable = 1'b1;
    D_opcode = 7'b0110011; D_rs1 = 5'd5; D_rs2 = 5'd1;
    cycle("lu_add");
    idle();
    cycle("lu_after");

    // lw x0 with Decode reading x0; lui x5 against lw x5
    E_opcode = 7'b0000011; E_rd = 5'd0; E_reg_write_enable = 1'b1;
    D_opcode = 7'b0110011; D_rs1 = 5'd0; D_rs2 = 5'd0;
    cycle("lu_x0");
    E_rd = 5'd5; D_opcode = 7'b0110111; D_rs1 = 5'd5; D_rs2 = 5'd5;
    cycle("lu_lui");
    // rs2 of an I-type is not read
    D_opcode = 7'b0010011; D_rs1 = 5'd1; D_rs2 = 5'd5;
    cycle("lu_itype_rs2");
    // store reads rs2
    D_opcode = 7'b0100011;
    cycle("lu_store_rs2");
    idle();

    // mul in Execute: LAT-1 stall cycles then RUN
    E_is_muldiv = 1'b1;
    for (int i = 0; i < int'(LAT); i++) cycle($sformatf("md_%0d", i));
    idle();
    cycle("md_done");

    // Memory wait in MD_WAIT with one mul/div stall cycle left
    E_is_muldiv = 1'b1;
    cycle("mdm_start");
    E_is_muldiv = 1'b0;
    cycle("mdm_cnt2");
    M_mem_req = 1'b1; M_mem_ready = 1'b0;
    cycle("mdm_memw0");
    cycle("mdm_memw1");
    M_mem_ready = 1'b1;
    cycle("mdm_ready");
    M_mem_req = 1'b0; M_mem_ready = 1'b0;
    cycle("mdm_cnt1");
    cycle("mdm_cnt0");
    cycle("mdm_run");

    // Redirect held through a mul/div acts only in the first RUN cycle
    E_branch_taken = 1'b1; E_is_muldiv = 1'b1;
    cycle("br_md_start");
    E_is_muldiv = 1'b0;
    for (int i = 0; i < int'(LAT); i++) cycle($sformatf("br_md_%0d", i));
    cycle("br_run2");
    idle();

    // Reset pulsed in MEM_WAIT abandons the wait
    M_mem_req = 1'b1; M_mem_ready = 1'b0;
    cycle("rst_mem_enter");
    cycle("rst_mem_hold");
    rst = 1'b1;
    cycle("rst_mem_pulse");
    idle();
    cycle("rst_mem_after");

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rst                = ($urandom_range(0, 99) == 0);
      D_rs1              = 5'($urandom_range(0, 3));
      D_rs2              = 5'($urandom_range(0, 3));
      D_opcode           = op_tab[$urandom_range(0, 7)];
      E_rd               = 5'($urandom_range(0, 3));
      E_opcode           = ($urandom_range(0, 1) == 0) ? 7'b0000011 : op_tab[$urandom_range(0, 7)];
      E_reg_write_enable = ($urandom_range(0, 3) != 0);
      E_is_muldiv        = ($urandom_range(0, 9) == 0);
      E_branch_taken     = ($urandom_range(0, 5) == 0);
      M_mem_req          = ($urandom_range(0, 4) == 0);
      M_mem_ready        = ($urandom_range(0, 1) == 0);
      cycle("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stall_flush_controller.md
STALL_FLUSH_CONTROLLER -- requirements
Module: stall_flush_controller

Interface
REQ-001 Parameter MULDIV_LATENCY, default 4, is the number of cycles a mul/div occupies Execute; legal range 1..16.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 D_rs1, D_rs2  input  5 each  Decode source register addresses.
REQ-005 D_opcode  input  7  Decode opcode.
REQ-006 E_rd  input  5  Execute destination register.
REQ-007 E_opcode  input  7  Execute opcode.
REQ-008 E_reg_write_enable  input  1  Execute instruction writes rd.
REQ-009 E_is_muldiv  input  1  Execute holds an M-extension instruction.
REQ-010 E_branch_taken  input  1  Execute redirects the PC (taken branch, jal, jalr).
REQ-011 M_mem_req, M_mem_ready  input  1 each  Memory-stage access request and completion.
REQ-012 F_stall, D_stall, E_stall, M_stall  output  1 each  hold the named stage's pipeline register.
REQ-013 D_flush, E_flush, M_flush, W_flush  output  1 each  load a bubble into the named stage's register.

Function
REQ-014 FSM states: RUN, MD_WAIT, MEM_WAIT. 4-bit down-counter md_cnt; 1-bit ret_md records the state to resume after MEM_WAIT.
REQ-015 Priority, highest first: memory wait, mul/div wait, redirect, load-use. All outputs are combinational from the state and the current inputs.
REQ-016 Memory wait: M_mem_req=1 and M_mem_ready=0 in RUN or MD_WAIT -> F/D/E/M_stall=1 and W_flush=1 that cycle; go to MEM_WAIT; ret_md=1 if coming from MD_WAIT.
REQ-017 MEM_WAIT: same outputs while M_mem_ready=0. In the first cycle with M_mem_ready=1, stalls drop and the state returns to MD_WAIT (if ret_md) or RUN. md_cnt is frozen throughout MEM_WAIT.
REQ-018 Mul/div: in RUN with E_is_muldiv=1 and MULDIV_LATENCY>1 -> F/D/E_stall=1 and M_flush=1; md_cnt<=MULDIV_LATENCY-2; go to MD_WAIT. MULDIV_LATENCY=1 causes no stall.
REQ-019 MD_WAIT: while md_cnt!=0, F/D/E_stall=1, M_flush=1 and md_cnt decrements. When md_cnt=0, there is no stall, Execute advances, and the state returns to RUN.
REQ-020 Total mul/div stall is exactly MULDIV_LATENCY-1 cycles; back-to-back mul/div each incur the full stall.
REQ-021 Redirect: RUN, no higher-priority condition, E_branch_taken=1 -> D_flush=1, E_flush=1, no stalls, load-use suppressed. Redirect is not acted on in MD_WAIT or MEM_WAIT; it is acted on in the first RUN cycle afterwards.
REQ-022 Load-use: RUN, no higher-priority condition, E_opcode=0000011, E_reg_write_enable=1, E_rd!=0, and E_rd equals a source Decode actually reads -> F_stall=D_stall=1 and E_flush=1 for exactly one cycle.
REQ-023 rs1 is not read for D_opcode 0110111, 0010111 or 1101111.
REQ-024 rs2 is read only for D_opcode 0110011, 0100011 or 1100011.
REQ-025 Register x0 never creates a hazard.
REQ-026 Any output not asserted by REQ-016..REQ-025 is 0.

Reset
REQ-027 While rst=1: state<=RUN, md_cnt<=0, ret_md<=0; all stalls 0; D/E/M/W_flush=1.
REQ-028 rst asserted mid-MD_WAIT or mid-MEM_WAIT abandons the operation; the first cycle after rst deasserts is RUN with no stall.

Configuration
REQ-029 Macro HAZARD_PERF_CNT_EN: when defined, adds outputs stall_cycles [31:0] (increments each cycle F_stall=1) and flush_events [31:0] (increments on each redirect flush).
REQ-030 Both counters clear on rst and wrap at 2^32.
REQ-031 When HAZARD_PERF_CNT_EN is undefined, these ports and counters do not exist and all other behaviour is identical.

Verification
REQ-032 lw x5 in Execute, add x6,x5,x1 in Decode -> one cycle F_stall=D_stall=E_flush=1, then outputs return to 0.
REQ-033 lw x0 in Execute, Decode reads x0; lui x5 in Decode vs lw x5 in Execute -> no stall in either case.
REQ-034 MULDIV_LATENCY=4, mul in Execute -> F/D/E_stall=1 and M_flush=1 for exactly 3 cycles, then RUN.
REQ-035 Case A: M_mem_ready low 2 cycles during MD_WAIT with md_cnt=1 -> 2 extra full-stall cycles, md_cnt held, then 1 MD_WAIT stall cycle. Case B: E_branch_taken=1 held throughout -> D_flush=E_flush=1 only in the first RUN cycle afterwards.
REQ-036 rst pulsed during MEM_WAIT -> all flushes=1 and stalls=0 while rst=1, RUN the next cycle; with HAZARD_PERF_CNT_EN defined, both counters read 0.
